// File: rtl/raster_scanner.sv
// Triangle setup and sample generation for the raster stage: bounding box, signed
// area and culling, then a ready/valid stream of sample positions in 1x or 4x MSAA.
`timescale 1ns/1ps
`default_nettype none

module raster_scanner #(
    parameter int X_RES     = 320,
    parameter int Y_RES     = 240,
    parameter int INT_BITS  = 9,
    parameter int FRAC_BITS = 8,
    parameter int SAMPLES   = 1,
    parameter int CULL_BACK = 1,
    parameter int ID_WIDTH  = 16,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [2:0][1:0][W-1:0]       vertices_in,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [1:0][W-1:0]            point_out,
    output logic [1:0]                   sample_out,
    output logic [ID_WIDTH-1:0]          triangle_id_out,
    output logic                         first_out,
    output logic                         last_out,
    output logic                         busy_out
);

    localparam int AW = 2 * W + 2;

    typedef logic [INT_BITS-1:0] pix_t;
    typedef enum logic [1:0] {IDLE, BOUND, CULL, SCAN} state_t;

    localparam logic [INT_BITS:0]    X_LIM  = (INT_BITS + 1)'(X_RES);
    localparam logic [INT_BITS:0]    Y_LIM  = (INT_BITS + 1)'(Y_RES);
    localparam pix_t                 X_MAX  = INT_BITS'(X_RES - 1);
    localparam pix_t                 Y_MAX  = INT_BITS'(Y_RES - 1);
    localparam logic [1:0]           S_LAST = 2'(SAMPLES - 1);
    localparam logic [FRAC_BITS-1:0] F_MID  = FRAC_BITS'(1 << (FRAC_BITS - 1));
    localparam logic [FRAC_BITS-1:0] F_LO   = FRAC_BITS'(1 << (FRAC_BITS - 2));
    localparam logic [FRAC_BITS-1:0] F_HI   = FRAC_BITS'(3 << (FRAC_BITS - 2));

    state_t                  state;
    logic [2:0][1:0][W-1:0]  vtx;
    pix_t                    min_col, max_col, min_row, max_row;
    logic signed [AW-1:0]    area;
    pix_t                    col, row;
    logic [1:0]              samp;
    logic [ID_WIDTH-1:0]     id_cnt;

    function automatic logic signed [AW-1:0] sext(input logic signed [W:0] v);
        return AW'(v);
    endfunction

    // Sample 0..3 walks the 2x2 grid x-first; single-sample mode uses the centre.
    function automatic logic [1:0][W-1:0] sample_point(input pix_t c, input pix_t r,
                                                       input logic [1:0] s);
        logic [FRAC_BITS-1:0] fx, fy;
        if (SAMPLES == 4) begin
            fx = s[0] ? F_HI : F_LO;
            fy = s[1] ? F_HI : F_LO;
        end else begin
            fx = F_MID;
            fy = F_MID;
        end
        return {r, fy, c, fx};
    endfunction

    // Setup arithmetic on the latched vertices.
    pix_t                 vx [3];
    pix_t                 vy [3];
    pix_t                 bx_min, bx_max, by_min, by_max;
    pix_t                 bx_max_c, by_max_c;
    logic signed [W:0]    dx1, dy1, dx2, dy2;
    logic signed [AW-1:0] area_c;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vx[i] = vtx[i][0][W-1:FRAC_BITS];
            vy[i] = vtx[i][1][W-1:FRAC_BITS];
        end
        bx_min = vx[0];
        bx_max = vx[0];
        by_min = vy[0];
        by_max = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < bx_min) bx_min = vx[i];
            if (vx[i] > bx_max) bx_max = vx[i];
            if (vy[i] < by_min) by_min = vy[i];
            if (vy[i] > by_max) by_max = vy[i];
        end
        bx_max_c = ({1'b0, bx_max} >= X_LIM) ? X_MAX : bx_max;
        by_max_c = ({1'b0, by_max} >= Y_LIM) ? Y_MAX : by_max;

        dx1    = $signed({1'b0, vtx[1][0]}) - $signed({1'b0, vtx[0][0]});
        dy1    = $signed({1'b0, vtx[1][1]}) - $signed({1'b0, vtx[0][1]});
        dx2    = $signed({1'b0, vtx[2][0]}) - $signed({1'b0, vtx[0][0]});
        dy2    = $signed({1'b0, vtx[2][1]}) - $signed({1'b0, vtx[0][1]});
        area_c = sext(dx1) * sext(dy2) - sext(dx2) * sext(dy1);
    end

    logic drop;
    always_comb begin
        drop = (area == '0)
            || ((CULL_BACK != 0) && (area < 0))
            || ({1'b0, min_col} >= X_LIM)
            || ({1'b0, min_row} >= Y_LIM);
    end

    // Next scan position: sample fastest, then column, then row.
    logic [1:0] nxt_samp;
    pix_t       nxt_col, nxt_row;
    logic       nxt_last;
    always_comb begin
        nxt_samp = samp;
        nxt_col  = col;
        nxt_row  = row;
        if (samp != S_LAST) begin
            nxt_samp = samp + 2'd1;
        end else begin
            nxt_samp = 2'd0;
            if (col == max_col) begin
                nxt_col = min_col;
                nxt_row = row + 1'b1;
            end else begin
                nxt_col = col + 1'b1;
            end
        end
        nxt_last = (nxt_row == max_row) && (nxt_col == max_col) && (nxt_samp == S_LAST);
    end

    // NOTE: pure datapath registers carry no reset; they are always written before use.
    always_ff @(posedge clk_in) begin
        if (state == IDLE && valid_in && ready_out) begin
            vtx <= vertices_in;
        end
        if (state == BOUND) begin
            min_col <= bx_min;
            max_col <= bx_max_c;
            min_row <= by_min;
            max_row <= by_max_c;
            area    <= area_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            ready_out       <= 1'b1;
            valid_out       <= 1'b0;
            first_out       <= 1'b0;
            last_out        <= 1'b0;
            busy_out        <= 1'b0;
            point_out       <= '0;
            sample_out      <= 2'd0;
            triangle_id_out <= '0;
            id_cnt          <= '0;
            col             <= '0;
            row             <= '0;
            samp            <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        triangle_id_out <= id_cnt;
                        id_cnt          <= id_cnt + ID_WIDTH'(1);
                        ready_out       <= 1'b0;
                        busy_out        <= 1'b1;
                        state           <= BOUND;
                    end
                end
                BOUND: begin
                    state <= CULL;
                end
                CULL: begin
                    if (drop) begin
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        col        <= min_col;
                        row        <= min_row;
                        samp       <= 2'd0;
                        valid_out  <= 1'b1;
                        point_out  <= sample_point(min_col, min_row, 2'd0);
                        sample_out <= 2'd0;
                        first_out  <= 1'b1;
                        last_out   <= (min_col == max_col) && (min_row == max_row)
                                      && (S_LAST == 2'd0);
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (ready_in) begin
                        if (last_out) begin
                            valid_out <= 1'b0;
                            first_out <= 1'b0;
                            last_out  <= 1'b0;
                            ready_out <= 1'b1;
                            busy_out  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            col        <= nxt_col;
                            row        <= nxt_row;
                            samp       <= nxt_samp;
                            point_out  <= sample_point(nxt_col, nxt_row, nxt_samp);
                            sample_out <= nxt_samp;
                            first_out  <= 1'b0;
                            last_out   <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_raster_scanner.sv
// Bench for raster_scanner: three instances (1x cull-back, 1x no-cull, 4x MSAA),
// a table of triangles with hand-derived boxes, and a sample scoreboard.
`timescale 1ns/1ps

module tb_raster_scanner;

    localparam int W  = 17;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [2:0][1:0][W-1:0] verts;
    logic                   valid_in  [ND];
    logic                   ready_out [ND];
    logic                   valid_out [ND];
    logic                   ready_in  [ND];
    logic [1:0][W-1:0]      point_out [ND];
    logic [1:0]             sample_out[ND];
    logic [15:0]            id_out    [ND];
    logic                   first_out [ND];
    logic                   last_out  [ND];
    logic                   busy_out  [ND];

    raster_scanner #(.SAMPLES(1), .CULL_BACK(1)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid_in[0]), .ready_out(ready_out[0]),
        .vertices_in(verts), .valid_out(valid_out[0]), .ready_in(ready_in[0]),
        .point_out(point_out[0]), .sample_out(sample_out[0]), .triangle_id_out(id_out[0]),
        .first_out(first_out[0]), .last_out(last_out[0]), .busy_out(busy_out[0]));

    raster_scanner #(.SAMPLES(1), .CULL_BACK(0)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid_in[1]), .ready_out(ready_out[1]),
        .vertices_in(verts), .valid_out(valid_out[1]), .ready_in(ready_in[1]),
        .point_out(point_out[1]), .sample_out(sample_out[1]), .triangle_id_out(id_out[1]),
        .first_out(first_out[1]), .last_out(last_out[1]), .busy_out(busy_out[1]));

    raster_scanner #(.SAMPLES(4), .CULL_BACK(1)) dut2 (
        .clk_in(clk), .rst_in(rst_n), .valid_in(valid_in[2]), .ready_out(ready_out[2]),
        .vertices_in(verts), .valid_out(valid_out[2]), .ready_in(ready_in[2]),
        .point_out(point_out[2]), .sample_out(sample_out[2]), .triangle_id_out(id_out[2]),
        .first_out(first_out[2]), .last_out(last_out[2]), .busy_out(busy_out[2]));

    typedef struct {
        int          d;
        logic [W-1:0] x, y;
        logic [1:0]  s;
        logic [15:0] id;
        logic        first, last;
    } smp_t;

    // Vertices in 1/256 pixel units; box and id derived by hand.
    typedef struct {
        string name;
        int    d;
        int    x0, y0, x1, y1, x2, y2;
        bit    cull;
        int    cmin, cmax, rmin, rmax;
        int    id;
        bit    stall;
    } vec_t;

    smp_t exp_q[$];
    smp_t obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Every accepted sample (valid && ready at the coming edge) is recorded.
    smp_t mon;
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (valid_out[d] && ready_in[d]) begin
                mon.d     = d;
                mon.x     = point_out[d][0];
                mon.y     = point_out[d][1];
                mon.s     = sample_out[d];
                mon.id    = id_out[d];
                mon.first = first_out[d];
                mon.last  = last_out[d];
                obs_q.push_back(mon);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input vec_t v);
        int   ns;
        smp_t e;
        ns = (v.d == 2) ? 4 : 1;
        for (int r = v.rmin; r <= v.rmax; r++)
            for (int c = v.cmin; c <= v.cmax; c++)
                for (int s = 0; s < ns; s++) begin
                    e.d     = v.d;
                    e.x     = W'(c * 256 + ((ns == 1) ? 'h80 : ((s & 1) != 0 ? 'hC0 : 'h40)));
                    e.y     = W'(r * 256 + ((ns == 1) ? 'h80 : ((s & 2) != 0 ? 'hC0 : 'h40)));
                    e.s     = 2'(s);
                    e.id    = 16'(v.id);
                    e.first = (r == v.rmin) && (c == v.cmin) && (s == 0);
                    e.last  = (r == v.rmax) && (c == v.cmax) && (s == ns - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic send(input vec_t v);
        int budget;
        verts[0][0] = W'(v.x0); verts[0][1] = W'(v.y0);
        verts[1][0] = W'(v.x1); verts[1][1] = W'(v.y1);
        verts[2][0] = W'(v.x2); verts[2][1] = W'(v.y2);
        budget = 0;
        while (!ready_out[v.d] && budget < 200) begin
            tick();
            budget++;
        end
        check({v.name, "_ready_before_accept"}, 64'(ready_out[v.d]), 64'd1);
        valid_in[v.d] = 1'b1;
        tick();
        valid_in[v.d] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        bit   stalled;
        smp_t e, o;
        if (!v.cull) push_expected(v);
        send(v);
        if (v.cull) begin
            check({v.name, "_ready_c1"}, 64'(ready_out[v.d]), 64'd0);
            check({v.name, "_busy_c1"},  64'(busy_out[v.d]),  64'd1);
            tick();
            check({v.name, "_ready_c2"}, 64'(ready_out[v.d]), 64'd0);
            tick();
            check({v.name, "_ready_c3"}, 64'(ready_out[v.d]), 64'd1);
            check({v.name, "_busy_c3"},  64'(busy_out[v.d]),  64'd0);
            check({v.name, "_no_valid"}, 64'(valid_out[v.d]), 64'd0);
            check({v.name, "_no_samples"}, 64'(obs_q.size()), 64'd0);
            obs_q.delete();
            return;
        end
        cyc = 0;
        stalled = 1'b0;
        while (busy_out[v.d] && cyc < 2000) begin
            if (v.stall && !stalled && obs_q.size() == 2) begin
                ready_in[v.d] = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    check({v.name, "_stall_valid"}, 64'(valid_out[v.d]), 64'd1);
                    check({v.name, "_stall_x"}, 64'(point_out[v.d][0]), 64'(exp_q[2].x));
                    check({v.name, "_stall_y"}, 64'(point_out[v.d][1]), 64'(exp_q[2].y));
                    tick();
                end
                ready_in[v.d] = 1'b1;
                stalled = 1'b1;
            end
            tick();
            cyc++;
        end
        check({v.name, "_scan_done"}, 64'(cyc < 2000), 64'd1);
        check({v.name, "_ready_after_last"}, 64'(ready_out[v.d]), 64'd1);
        check({v.name, "_sample_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({v.name, "_dut"},    64'(o.d),     64'(e.d));
            check({v.name, "_x"},      64'(o.x),     64'(e.x));
            check({v.name, "_y"},      64'(o.y),     64'(e.y));
            check({v.name, "_sample"}, 64'(o.s),     64'(e.s));
            check({v.name, "_id"},     64'(o.id),    64'(e.id));
            check({v.name, "_first"},  64'(o.first), 64'(e.first));
            check({v.name, "_last"},   64'(o.last),  64'(e.last));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    vec_t tbl[10];
    vec_t t1;
    int   cyc;

    initial begin
        //          name        d  x0     y0     x1      y1     x2     y2   cull cmin cmax rmin rmax id stall
        tbl[0] = '{"t1",        0, 256,   256,   896,    256,   256,   640,   0, 1,   3,   1,   2,   0, 1};
        tbl[1] = '{"swap_cull", 0, 256,   256,   256,    640,   896,   256,   1, 0,   0,   0,   0,   1, 0};
        tbl[2] = '{"degen",     0, 256,   256,   512,    512,   768,   768,   1, 0,   0,   0,   0,   2, 0};
        tbl[3] = '{"clamp_x",   0, 76800, 2560,  102400, 2560,  76800, 3072,  0, 300, 319, 10,  12,  3, 0};
        tbl[4] = '{"off_x",     0, 81920, 1280,  84480,  1280,  81920, 1792,  1, 0,   0,   0,   0,   4, 0};
        tbl[5] = '{"off_y",     0, 2560,  61440, 3072,   61440, 2560,  61952, 1, 0,   0,   0,   0,   5, 0};
        tbl[6] = '{"t1_again",  0, 256,   256,   896,    256,   256,   640,   0, 1,   3,   1,   2,   6, 0};
        tbl[7] = '{"swap_keep", 1, 256,   256,   256,    640,   896,   256,   0, 1,   3,   1,   2,   0, 0};
        tbl[8] = '{"msaa_pix",  2, 544,   544,   672,    544,   544,   672,   0, 2,   2,   2,   2,   0, 0};
        tbl[9] = '{"msaa_two",  2, 256,   256,   640,    256,   256,   384,   0, 1,   2,   1,   1,   1, 0};

        rst_n = 1'b0;
        verts = '0;
        for (int d = 0; d < ND; d++) begin
            valid_in[d] = 1'b0;
            ready_in[d] = 1'b1;
        end
        repeat (3) tick();
        check("rst_valid", 64'(valid_out[0]),  64'd0);
        check("rst_busy",  64'(busy_out[0]),   64'd0);
        check("rst_point", 64'(point_out[0]),  64'd0);
        rst_n = 1'b1;
        tick();
        check("init_ready",  64'(ready_out[0]),  64'd1);
        check("init_valid",  64'(valid_out[0]),  64'd0);
        check("init_busy",   64'(busy_out[0]),   64'd0);
        check("init_id",     64'(id_out[0]),     64'd0);
        check("init_sample", 64'(sample_out[0]), 64'd0);
        check("init_first",  64'(first_out[0]),  64'd0);
        check("init_last",   64'(last_out[0]),   64'd0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Reset in the middle of a scan abandons the triangle.
        t1 = tbl[0];
        t1.stall = 1'b0;
        t1.name = "mid_rst";
        send(t1);
        cyc = 0;
        while (obs_q.size() < 3 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("mid_rst_reached_scan", 64'(cyc < 100), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(valid_out[0]), 64'd0);
        check("mid_rst_busy",  64'(busy_out[0]),  64'd0);
        check("mid_rst_id",    64'(id_out[0]),    64'd0);
        check("mid_rst_first", 64'(first_out[0]), 64'd0);
        check("mid_rst_last",  64'(last_out[0]),  64'd0);
        rst_n = 1'b1;
        obs_q.delete();
        tick();
        check("post_rst_ready", 64'(ready_out[0]), 64'd1);
        check("post_rst_valid", 64'(valid_out[0]), 64'd0);
        check("post_rst_no_samples", 64'(obs_q.size()), 64'd0);
        t1.name = "post_rst_t1";
        t1.id = 0;
        run_vec(t1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
